axil_cmd_master: RTL and testbench
==================================

AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

Interface
REQ-001 SHALL have parameter: AW, default 32, width of the AXI address bus and command address.
REQ-002 SHALL have port: clk  input  1  the single clock; all logic on its rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: cmd_write  input  1  one-cycle pulse that starts an AXI4-Lite write.
REQ-005 SHALL have port: cmd_read  input  1  one-cycle pulse that starts an AXI4-Lite read.
REQ-006 SHALL have ports: cmd_addr  input  AW  byte address; cmd_wdata  input  32  write data; cmd_wstrb  input  4  write byte strobes.
REQ-007 SHALL have ports: rsp_rdata  output  32  read data; rsp_resp  output  2  captured BRESP or RRESP; rsp_done  output  1  one-cycle completion pulse; idle  output  1  high when a new command can be accepted.
REQ-008 SHALL have the AXI4-Lite master ports M_AXI_AWADDR(AW), AWVALID, AWREADY, AWPROT(3); WDATA(32), WSTRB(4), WVALID, WREADY; BRESP(2), BVALID, BREADY; ARADDR(AW), ARVALID, ARREADY, ARPROT(3); RDATA(32), RRESP(2), RVALID, RREADY, with the usual directions for a master.

Function
REQ-009 SHALL implement the states IDLE, WR_REQ, WR_RESP, RD_REQ and RD_RESP.
REQ-010 SHALL drive idle combinationally as (state == IDLE).
REQ-011 SHALL accept a command only in IDLE; commands in any other state are ignored with no side effects.
REQ-012 SHALL, on cmd_write and cmd_read in the same IDLE cycle, execute only the write and discard the read.
REQ-013 SHALL latch cmd_addr, cmd_wdata and cmd_wstrb at acceptance; later changes to the command inputs have no effect on the transaction in flight.
REQ-014 SHALL, on cmd_write accepted in cycle N, enter WR_REQ with AWVALID=1 and WVALID=1 registered from cycle N+1.
REQ-015 SHALL, in WR_REQ, deassert AWVALID on the edge after AWVALID&&AWREADY.
REQ-016 SHALL, in WR_REQ, deassert WVALID on the edge after WVALID&&WREADY, independently of the AW handshake and in either order or the same cycle.
REQ-017 SHALL move from WR_REQ to WR_RESP when both handshakes have completed, with BREADY=1 in WR_RESP only.
REQ-018 SHALL, on BVALID&&BREADY, latch BRESP into rsp_resp, pulse rsp_done for exactly one cycle on the next edge, deassert BREADY, and return to IDLE.
REQ-019 SHALL, on cmd_read accepted in cycle N, enter RD_REQ with ARVALID=1 from cycle N+1, and deassert it and enter RD_RESP on the edge after ARVALID&&ARREADY.
REQ-020 SHALL hold RREADY=1 only in RD_RESP, and on RVALID&&RREADY latch RDATA into rsp_rdata and RRESP into rsp_resp, pulse rsp_done for one cycle, and return to IDLE.
REQ-021 SHALL keep every VALID asserted, with address, data and strobes stable, until its handshake completes, regardless of the READY level.
REQ-022 SHALL drive AWPROT and ARPROT as 3'b000 constantly.
REQ-023 SHALL leave rsp_rdata unchanged after a write and rsp_resp unchanged until the next completion.
REQ-024 SHALL allow a new command in the cycle rsp_done is high, since idle is already 1; the minimum back-to-back spacing is set by these handshakes alone.

Reset
REQ-025 SHALL, while reset=1 at a clock edge, go to IDLE and set AWVALID, WVALID, BREADY, ARVALID, RREADY and rsp_done to 0, and rsp_rdata and rsp_resp to 0.
REQ-026 SHALL, on reset mid-transaction, abandon that transaction silently with no rsp_done, and drop all VALID and READY outputs on the reset edge.

Verification
REQ-027 SHALL be verified: cmd_write addr=0x0 data=0x0000A5A5 strb=0xF, slave with AWREADY/WREADY=1 and BRESP=OKAY -> AW and W handshakes in cycle N+1, rsp_done=1 with rsp_resp=0 two cycles after the B handshake cycle at the latest, idle=1.
REQ-028 SHALL be verified: write where WREADY lags AWREADY by 3 cycles -> AWVALID drops after 1 cycle, WVALID holds 4 cycles, BREADY rises only after both handshakes.
REQ-029 SHALL be verified: cmd_read addr=0x0 with the slave returning RDATA=0x12345678 and RRESP=OKAY after a 2-cycle RVALID delay -> rsp_rdata=0x12345678, rsp_resp=0, one rsp_done pulse.
REQ-030 SHALL be verified: read of addr=0x4 with slave RRESP=DECERR(3) -> rsp_resp=3, rsp_rdata equal to RDATA, done pulse.
REQ-031 SHALL be verified: cmd_write and cmd_read in the same cycle, and also cmd_read issued during WR_RESP -> only one write occurs and ARVALID never rises.
REQ-032 SHALL be verified: reset asserted while in WR_RESP -> next cycle all VALID and READY outputs are 0, idle=1, no rsp_done, and a following read completes normally.

Source files
------------

// File: rtl/axil_cmd_master_if.sv
// ---------------------------------------------------------------------------
// axil_cmd_master_if
//   AXI4-Lite bus bundle between the command master and a slave.
//   Parameter AW sets the address width of AWADDR/ARADDR.
//   Channels:
//     AW : awaddr, awprot, awvalid (master) / awready (slave)
//     W  : wdata, wstrb, wvalid (master)    / wready (slave)
//     B  : bresp, bvalid (slave)            / bready (master)
//     AR : araddr, arprot, arvalid (master) / arready (slave)
//     R  : rdata, rresp, rvalid (slave)     / rready (master)
//   Handshake rule on every channel: a transfer happens on a rising clk edge
//   where VALID and READY are both 1; the VALID side holds VALID and its
//   payload stable until that edge, and never waits on READY to raise VALID.
// ---------------------------------------------------------------------------
interface axil_cmd_master_if #(
   parameter int AW = 32
);
   logic [AW-1:0] awaddr;
   logic [2:0]    awprot;
   logic          awvalid;
   logic          awready;

   logic [31:0]   wdata;
   logic [3:0]    wstrb;
   logic          wvalid;
   logic          wready;

   logic [1:0]    bresp;
   logic          bvalid;
   logic          bready;

   logic [AW-1:0] araddr;
   logic [2:0]    arprot;
   logic          arvalid;
   logic          arready;

   logic [31:0]   rdata;
   logic [1:0]    rresp;
   logic          rvalid;
   logic          rready;

   modport master (
      output awaddr, awprot, awvalid,
      input  awready,
      output wdata, wstrb, wvalid,
      input  wready,
      input  bresp, bvalid,
      output bready,
      output araddr, arprot, arvalid,
      input  arready,
      input  rdata, rresp, rvalid,
      output rready
   );

   modport slave (
      input  awaddr, awprot, awvalid,
      output awready,
      input  wdata, wstrb, wvalid,
      output wready,
      output bresp, bvalid,
      input  bready,
      input  araddr, arprot, arvalid,
      output arready,
      output rdata, rresp, rvalid,
      input  rready
   );
endinterface

// File: rtl/axil_cmd_master.sv
// ---------------------------------------------------------------------------
// axil_cmd_master
//   Turns single-cycle write/read command pulses into one AXI4-Lite
//   transaction at a time and reports the outcome.
//   Ports:
//     clk, reset         : clock, synchronous active-high reset
//     cmd_write/cmd_read : one-cycle start pulses (write wins if both)
//     cmd_addr/wdata/wstrb : command payload, latched at acceptance
//     rsp_rdata/rsp_resp : last read data / last BRESP or RRESP
//     rsp_done           : one-cycle completion pulse
//     idle               : 1 when a command will be accepted this cycle
//     dbg_state_o        : current FSM state for observation
//     m_axi              : AXI4-Lite master side of the bus
// ---------------------------------------------------------------------------
module axil_cmd_master #(
   parameter int AW = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cmd_write,
   input  logic            cmd_read,
   input  logic [AW-1:0]   cmd_addr,
   input  logic [31:0]     cmd_wdata,
   input  logic [3:0]      cmd_wstrb,
   output logic [31:0]     rsp_rdata,
   output logic [1:0]      rsp_resp,
   output logic            rsp_done,
   output logic            idle,
   output logic [2:0]      dbg_state_o,
   axil_cmd_master_if.master m_axi
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_REQ  = 3'd1,
      WR_RESP = 3'd2,
      RD_REQ  = 3'd3,
      RD_RESP = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [3:0]    wstrb_q, wstrb_d;
   logic          awvalid_q, awvalid_d;
   logic          wvalid_q, wvalid_d;
   logic          bready_q, bready_d;
   logic          arvalid_q, arvalid_d;
   logic          rready_q, rready_d;
   logic [31:0]   rsp_rdata_q, rsp_rdata_d;
   logic [1:0]    rsp_resp_q, rsp_resp_d;
   logic          rsp_done_q, rsp_done_d;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      bready_d    = bready_q;
      arvalid_d   = arvalid_q;
      rready_d    = rready_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_resp_d  = rsp_resp_q;
      rsp_done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            // A simultaneous read request is dropped: write has priority.
            if (cmd_write) begin
               addr_d    = cmd_addr;
               wdata_d   = cmd_wdata;
               wstrb_d   = cmd_wstrb;
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
               state_d   = WR_REQ;
            end else if (cmd_read) begin
               addr_d    = cmd_addr;
               arvalid_d = 1'b1;
               state_d   = RD_REQ;
            end
         end

         WR_REQ: begin
            // AW and W retire independently; a channel already retired
            // simply stays low until the other one catches up.
            if (awvalid_q && m_axi.awready) awvalid_d = 1'b0;
            if (wvalid_q && m_axi.wready)   wvalid_d  = 1'b0;
            if (!awvalid_d && !wvalid_d) begin
               bready_d = 1'b1;
               state_d  = WR_RESP;
            end
         end

         WR_RESP: begin
            if (m_axi.bvalid && bready_q) begin
               rsp_resp_d = m_axi.bresp;
               rsp_done_d = 1'b1;
               bready_d   = 1'b0;
               state_d    = IDLE;
            end
         end

         RD_REQ: begin
            if (arvalid_q && m_axi.arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = RD_RESP;
            end
         end

         RD_RESP: begin
            if (m_axi.rvalid && rready_q) begin
               rsp_rdata_d = m_axi.rdata;
               rsp_resp_d  = m_axi.rresp;
               rsp_done_d  = 1'b1;
               rready_d    = 1'b0;
               state_d     = IDLE;
            end
         end

         default: begin
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
            state_d   = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= '0;
         rsp_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_resp_q  <= rsp_resp_d;
         rsp_done_q  <= rsp_done_d;
      end
   end

   // Reads and writes never overlap, so one latched address serves both.
   assign m_axi.awaddr  = addr_q;
   assign m_axi.awprot  = 3'b000;
   assign m_axi.awvalid = awvalid_q;
   assign m_axi.wdata   = wdata_q;
   assign m_axi.wstrb   = wstrb_q;
   assign m_axi.wvalid  = wvalid_q;
   assign m_axi.bready  = bready_q;
   assign m_axi.araddr  = addr_q;
   assign m_axi.arprot  = 3'b000;
   assign m_axi.arvalid = arvalid_q;
   assign m_axi.rready  = rready_q;

   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_resp    = rsp_resp_q;
   assign rsp_done    = rsp_done_q;
   assign idle        = (state_q == IDLE);
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
module tb_axil_cmd_master;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_write, cmd_read;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_done, idle;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  axil_cmd_master_if #(.AW(32)) bus ();

  axil_cmd_master #(.AW(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_write   (cmd_write),
    .cmd_read    (cmd_read),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_wstrb   (cmd_wstrb),
    .rsp_rdata   (rsp_rdata),
    .rsp_resp    (rsp_resp),
    .rsp_done    (rsp_done),
    .idle        (idle),
    .dbg_state_o (dbg_state),
    .m_axi       (bus.master)
  );

  // ---------------- scoreboard state ----------------
  int vectors = 0;
  int miscompares = 0;

  logic [31:0] exp_aw_q[$];   // addresses the slave should see on AW
  logic [35:0] exp_w_q[$];    // {wdata, wstrb} the slave should see on W
  logic [31:0] exp_ar_q[$];   // addresses the slave should see on AR
  logic [1:0]  slv_b_q[$];    // BRESP the slave returns per write
  logic [33:0] slv_r_q[$];    // {rdata, rresp} the slave returns per read
  logic [33:0] exp_q[$];      // expected {rsp_rdata, rsp_resp} per completion

  logic [31:0] last_rdata = '0;  // model of the read-data result register

  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  int issue_edge = 0;

  // statistics written only by the slave / monitor processes
  int aw_edge = 0, w_edge = 0, b_edge = 0, done_edge = 0;
  int aw_hs_n = 0, aw_hi = 0, w_hi = 0, ar_rise_n = 0, done_n = 0;
  int bready_rise_edge = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: event observed 1, required 0", name);
  endtask

  // ---------------- slave model ----------------
  // Decisions are made on the falling edge; a handshake decided here takes
  // effect on the following rising edge.
  bit aw_f, w_f, ar_f, b_fire, r_fire, aw_pend, w_pend, ar_pend;
  int aw_wait, w_wait, ar_wait, b_wait, r_wait;

  always @(negedge clk) begin
    logic [35:0] ew;
    logic [33:0] er;
    if (reset) begin
      bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
      bus.bvalid = 1'b0; bus.bresp = '0;
      bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = '0;
      aw_f = 0; w_f = 0; ar_f = 0; b_fire = 0; r_fire = 0;
      aw_pend = 0; w_pend = 0; ar_pend = 0;
      aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
    end else begin
      // B: only after both AW and W completed on earlier edges
      if (b_fire) begin
        bus.bvalid = 1'b0; b_fire = 0; aw_f = 0; w_f = 0; b_wait = 0;
      end else if (aw_f && w_f) begin
        if (b_wait >= b_dly) begin
          if (!bus.bvalid) begin
            bus.bvalid = 1'b1;
            bus.bresp  = (slv_b_q.size() > 0) ? slv_b_q[0] : 2'b00;
          end
          if (bus.bready) begin
            b_fire = 1; b_edge = cyc + 1;
            if (slv_b_q.size() > 0) void'(slv_b_q.pop_front());
          end
        end else b_wait++;
      end
      // R: only after AR completed on an earlier edge
      if (r_fire) begin
        bus.rvalid = 1'b0; r_fire = 0; ar_f = 0; r_wait = 0;
      end else if (ar_f) begin
        if (r_wait >= r_dly) begin
          if (!bus.rvalid) begin
            er = (slv_r_q.size() > 0) ? slv_r_q[0] : 34'h0;
            bus.rvalid = 1'b1; bus.rdata = er[33:2]; bus.rresp = er[1:0];
          end
          if (bus.rready) begin
            r_fire = 1;
            if (slv_r_q.size() > 0) void'(slv_r_q.pop_front());
          end
        end else r_wait++;
      end
      // AW
      if (bus.awvalid) begin
        aw_hi++;
        check("awprot", bus.awprot, 3'b000);
        if (exp_aw_q.size() == 0) fail("aw_unexpected");
        else check("awaddr", bus.awaddr, exp_aw_q[0]);
        if (aw_wait >= aw_dly) begin
          bus.awready = 1'b1; aw_f = 1; aw_edge = cyc + 1; aw_hs_n++;
          aw_wait = 0; aw_pend = 0;
          if (exp_aw_q.size() > 0) void'(exp_aw_q.pop_front());
        end else begin
          bus.awready = 1'b0; aw_wait++; aw_pend = 1;
        end
      end else begin
        if (aw_pend) check("awvalid_held", bus.awvalid, 1'b1);
        aw_pend = 0;
        bus.awready = 1'($urandom_range(0, 1));
      end
      // W
      if (bus.wvalid) begin
        w_hi++;
        if (exp_w_q.size() == 0) fail("w_unexpected");
        else begin
          ew = exp_w_q[0];
          check("wdata", bus.wdata, ew[35:4]);
          check("wstrb", bus.wstrb, ew[3:0]);
        end
        if (w_wait >= w_dly) begin
          bus.wready = 1'b1; w_f = 1; w_edge = cyc + 1; w_wait = 0; w_pend = 0;
          if (exp_w_q.size() > 0) void'(exp_w_q.pop_front());
        end else begin
          bus.wready = 1'b0; w_wait++; w_pend = 1;
        end
      end else begin
        if (w_pend) check("wvalid_held", bus.wvalid, 1'b1);
        w_pend = 0;
        bus.wready = 1'($urandom_range(0, 1));
      end
      // AR
      if (bus.arvalid) begin
        check("arprot", bus.arprot, 3'b000);
        if (exp_ar_q.size() == 0) fail("ar_unexpected");
        else check("araddr", bus.araddr, exp_ar_q[0]);
        if (ar_wait >= ar_dly) begin
          bus.arready = 1'b1; ar_f = 1; ar_wait = 0; ar_pend = 0;
          if (exp_ar_q.size() > 0) void'(exp_ar_q.pop_front());
        end else begin
          bus.arready = 1'b0; ar_wait++; ar_pend = 1;
        end
      end else begin
        if (ar_pend) check("arvalid_held", bus.arvalid, 1'b1);
        ar_pend = 0;
        bus.arready = 1'($urandom_range(0, 1));
      end
    end
  end

  // ---------------- response monitor ----------------
  logic prev_done = 1'b0, prev_ar = 1'b0, prev_bready = 1'b0;

  always @(negedge clk) begin
    logic [33:0] e;
    if (!reset) begin
      if (bus.arvalid && !prev_ar) ar_rise_n++;
      if (bus.bready && !prev_bready) bready_rise_edge = cyc;
      if (bus.bready && (bus.awvalid || bus.wvalid)) fail("bready_during_req");
      if (rsp_done) begin
        done_n++;
        done_edge = cyc;
        check("done_single_cycle", prev_done, 1'b0);
        check("idle_at_done", idle, 1'b1);
        if (exp_q.size() == 0) fail("done_unexpected");
        else begin
          e = exp_q.pop_front();
          check("rsp_rdata", rsp_rdata, e[33:2]);
          check("rsp_resp", rsp_resp, e[1:0]);
        end
      end
    end
    prev_done   = rsp_done;
    prev_ar     = bus.arvalid;
    prev_bready = bus.bready;
  end

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic wait_idle();
    int n = 0;
    while (!idle && n < 300) begin @(negedge clk); n++; end
    if (!idle) fail("idle_timeout");
  endtask

  task automatic end_cmd();
    @(negedge clk);
    cmd_write = 1'b0; cmd_read = 1'b0;
    cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
  endtask

  task automatic issue_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [1:0] br, input bit with_read);
    wait_idle();
    cmd_write = 1'b1; cmd_read = with_read;
    cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    exp_aw_q.push_back(a);
    exp_w_q.push_back({d, s});
    slv_b_q.push_back(br);
    exp_q.push_back({last_rdata, br});
    issue_edge = cyc + 1;
    end_cmd();
  endtask

  task automatic issue_read(input logic [31:0] a, input logic [31:0] rd, input logic [1:0] rr);
    wait_idle();
    cmd_read = 1'b1; cmd_addr = a;
    exp_ar_q.push_back(a);
    slv_r_q.push_back({rd, rr});
    exp_q.push_back({rd, rr});
    last_rdata = rd;
    issue_edge = cyc + 1;
    end_cmd();
  endtask

  task automatic wait_quiet();
    int n = 0;
    while ((exp_q.size() != 0 || !idle) && n < 300) begin @(negedge clk); n++; end
    if (exp_q.size() != 0 || !idle) fail("completion_timeout");
  endtask

  task automatic wait_bready();
    int n = 0;
    while (!bus.bready && n < 100) begin @(negedge clk); n++; end
    if (!bus.bready) fail("bready_timeout");
  endtask

  task automatic check_outputs_quiet(input string tag);
    check({tag, "_awvalid"}, bus.awvalid, 1'b0);
    check({tag, "_wvalid"},  bus.wvalid,  1'b0);
    check({tag, "_bready"},  bus.bready,  1'b0);
    check({tag, "_arvalid"}, bus.arvalid, 1'b0);
    check({tag, "_rready"},  bus.rready,  1'b0);
    check({tag, "_idle"},    idle,        1'b1);
    check({tag, "_done"},    rsp_done,    1'b0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    fail("global_timeout");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    int d0, a0, r0, h0, awh0, wh0;
    reset = 1'b1;
    cmd_write = 1'b0; cmd_read = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    repeat (3) @(negedge clk);

    // reset state
    check_outputs_quiet("reset");
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    check("reset_rsp_resp", rsp_resp, 2'b00);
    check("reset_awprot", bus.awprot, 3'b000);
    check("reset_arprot", bus.arprot, 3'b000);
    reset = 1'b0;
    @(negedge clk);

    // basic write, zero-wait slave
    issue_write(32'h0, 32'h0000A5A5, 4'hF, 2'b00, 1'b0);
    wait_quiet();
    check("wr_aw_edge", aw_edge, issue_edge + 1);
    check("wr_w_edge", w_edge, issue_edge + 1);
    check("wr_done_latency", (done_edge >= b_edge) && (done_edge <= b_edge + 2), 1'b1);
    check("wr_idle_after", idle, 1'b1);

    // WREADY lags AWREADY by 3 cycles
    w_dly = 3; awh0 = aw_hi; wh0 = w_hi;
    issue_write(32'h0000_0040, 32'hDEAD_BEEF, 4'h5, 2'b10, 1'b0);
    wait_quiet();
    check("lag_awvalid_cycles", aw_hi - awh0, 1);
    check("lag_wvalid_cycles", w_hi - wh0, 4);
    check("lag_bready_after_both", (bready_rise_edge >= w_edge) && (bready_rise_edge >= aw_edge), 1'b1);
    w_dly = 0;

    // read with 2-cycle RVALID delay
    r_dly = 2; d0 = done_n;
    issue_read(32'h0, 32'h12345678, 2'b00);
    wait_quiet();
    check("rd_done_count", done_n - d0, 1);
    r_dly = 0;

    // read returning DECERR
    d0 = done_n;
    issue_read(32'h4, $urandom, 2'b11);
    wait_quiet();
    check("decerr_done_count", done_n - d0, 1);

    // write+read together, then read during WR_RESP
    b_dly = 4; d0 = done_n; a0 = ar_rise_n; h0 = aw_hs_n;
    issue_write(32'h10, $urandom, 4'($urandom), 2'b01, 1'b1);
    wait_bready();
    cmd_read = 1'b1; cmd_addr = 32'h20;
    end_cmd();
    wait_quiet();
    check("both_write_count", aw_hs_n - h0, 1);
    check("both_arvalid_rises", ar_rise_n - a0, 0);
    check("both_done_count", done_n - d0, 1);

    // reset while in WR_RESP
    b_dly = 30;
    issue_write(32'h8, $urandom, 4'hF, 2'b00, 1'b0);
    wait_bready();
    reset = 1'b1; cmd_write = 1'b0; cmd_read = 1'b0;
    exp_aw_q.delete(); exp_w_q.delete(); exp_ar_q.delete();
    slv_b_q.delete(); slv_r_q.delete(); exp_q.delete();
    last_rdata = '0;
    d0 = done_n;
    @(negedge clk);
    check_outputs_quiet("midreset");
    check("midreset_rsp_resp", rsp_resp, 2'b00);
    @(negedge clk);
    reset = 1'b0; b_dly = 0;
    repeat (5) @(negedge clk);
    check("midreset_no_done", done_n - d0, 0);
    issue_read(32'h30, $urandom, 2'b00);
    wait_quiet();
    check("post_reset_read_done", done_n - d0, 1);

    // randomized back-to-back traffic
    for (int i = 0; i < 120; i++) begin
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
      b_dly  = $urandom_range(0, 4); ar_dly = $urandom_range(0, 3);
      r_dly  = $urandom_range(0, 4);
      if ($urandom_range(0, 1) == 1)
        issue_write({$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, $urandom, 4'($urandom), 2'($urandom), 1'b0);
      else
        issue_read({$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, $urandom, 2'($urandom));
      if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    wait_quiet();
    check("final_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
